// File: rtl/ifetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues one read at a time to a
// multi-cycle instruction memory and hands words to decode via a 2-entry buffer.
module ifetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic        mem_stall,
    input  logic        mem_done,
    input  logic [15:0] mem_data_in,
    output logic [15:0] instr,
    output logic [15:0] pc_plus,
    output logic        instr_valid,
    input  logic        decode_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        err
);

    localparam int unsigned XLEN = 16;
    localparam int unsigned CW   = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_DROP   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] tag_pc_q, tag_pc_d;
    logic [XLEN-1:0] instr0_q, instr0_d, instr1_q, instr1_d;
    logic [XLEN-1:0] pcp0_q, pcp0_d, pcp1_q, pcp1_d;
    logic [CW-1:0]   count_q, count_d;
    logic            halt_seen_q, halt_seen_d;
    logic            err_q, err_d;

    logic            credit;
    logic            accept;
    logic            redirect_act;
    logic            push;
    logic            pop;

    assign mem_addr    = fetch_pc_q;
    assign instr       = instr0_q;
    assign pc_plus     = pcp0_q;
    assign instr_valid = (count_q != '0);
    assign err         = err_q;

    // Next-state, fetch PC, buffer and error logic
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        tag_pc_d    = tag_pc_q;
        instr0_d    = instr0_q;
        instr1_d    = instr1_q;
        pcp0_d      = pcp0_q;
        pcp1_d      = pcp1_q;
        count_d     = count_q;
        halt_seen_d = halt_seen_q;
        err_d       = err_q;

        // Occupancy plus the one possible outstanding read must leave room for a push
        credit       = (count_q + CW'(state_q == S_WAIT)) < CW'(2);
        mem_rd       = (state_q == S_IDLE) && credit && !redirect && !halt
                       && !halt_seen_q && !rst;
        accept       = mem_rd && !mem_stall;
        redirect_act = redirect && (state_q != S_HALTED);
        push         = (state_q == S_WAIT) && mem_done && !redirect_act;
        pop          = instr_valid && decode_ready && !redirect_act;

        if (halt && (state_q != S_HALTED)) begin
            halt_seen_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (mem_done) begin
                    err_d = 1'b1;
                end
                if (halt_seen_q) begin
                    state_d = S_HALTED;
                end else if (accept) begin
                    state_d    = S_WAIT;
                    fetch_pc_d = fetch_pc_q + XLEN'(2);
                    tag_pc_d   = fetch_pc_q + XLEN'(2);
                end
            end
            S_WAIT: begin
                if (mem_done) begin
                    state_d = S_IDLE;
                end else if (redirect_act) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (mem_done) begin
                    state_d = S_IDLE;
                end
            end
            S_HALTED: begin
                if (mem_done) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect_act) begin
            fetch_pc_d = redirect_pc;
            count_d    = '0;
            if (redirect_pc[0]) begin
                err_d = 1'b1;
            end
        end else begin
            // Head always lives in entry 0 so instr/pc_plus come straight from flops
            case ({push, pop})
                2'b11: begin
                    if (count_q == CW'(1)) begin
                        instr0_d = mem_data_in;
                        pcp0_d   = tag_pc_q;
                    end else begin
                        instr0_d = instr1_q;
                        pcp0_d   = pcp1_q;
                        instr1_d = mem_data_in;
                        pcp1_d   = tag_pc_q;
                    end
                end
                2'b10: begin
                    if (count_q == '0) begin
                        instr0_d = mem_data_in;
                        pcp0_d   = tag_pc_q;
                    end else begin
                        instr1_d = mem_data_in;
                        pcp1_d   = tag_pc_q;
                    end
                    count_d = count_q + CW'(1);
                end
                2'b01: begin
                    instr0_d = instr1_q;
                    pcp0_d   = pcp1_q;
                    count_d  = count_q - CW'(1);
                end
                default: ;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC;
            tag_pc_q    <= '0;
            instr0_q    <= '0;
            instr1_q    <= '0;
            pcp0_q      <= '0;
            pcp1_q      <= '0;
            count_q     <= '0;
            halt_seen_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            tag_pc_q    <= tag_pc_d;
            instr0_q    <= instr0_d;
            instr1_q    <= instr1_d;
            pcp0_q      <= pcp0_d;
            pcp1_q      <= pcp1_d;
            count_q     <= count_d;
            halt_seen_q <= halt_seen_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: per-cycle vectors of inputs and hand-computed
// outputs, driven on the falling edge and checked 1ns later.
module tb_ifetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_stall;
    logic        mem_done;
    logic [15:0] mem_data_in;
    logic [15:0] instr;
    logic [15:0] pc_plus;
    logic        instr_valid;
    logic        decode_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    ifetch_stage #(.RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_stall    (mem_stall),
        .mem_done     (mem_done),
        .mem_data_in  (mem_data_in),
        .instr        (instr),
        .pc_plus      (pc_plus),
        .instr_valid  (instr_valid),
        .decode_ready (decode_ready),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .halt         (halt),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        stall;
        logic        done;
        logic [15:0] data;
        logic        rdy;
        logic        redir;
        logic [15:0] rpc;
        logic        halt;
        logic        e_rd;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [15:0] e_pcp;
        logic        e_err;
        logic        ck;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string n, input logic r, input logic st, input logic dn,
                       input logic [15:0] d, input logic rdy, input logic rd_i,
                       input logic [15:0] rpc, input logic h, input logic erd,
                       input logic [15:0] ea, input logic ev, input logic [15:0] ei,
                       input logic [15:0] ep, input logic ee);
        vec_t v;
        v.name = n; v.rst = r; v.stall = st; v.done = dn; v.data = d; v.rdy = rdy;
        v.redir = rd_i; v.rpc = rpc; v.halt = h; v.e_rd = erd; v.e_addr = ea;
        v.e_valid = ev; v.e_instr = ei; v.e_pcp = ep; v.e_err = ee; v.ck = 1'b1;
        vq.push_back(v);
    endtask

    // Reset row: registered outputs still show the previous segment, so only mem_rd is checked
    task automatic add_rst(input string n);
        add(n, 1, 0, 0, 16'h0, 1, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0, 16'h0, 0);
        vq[vq.size()-1].ck = 1'b0;
    endtask

    task automatic chk(input string n, input string f, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %h expected %h", n, f, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.rst; mem_stall = v.stall; mem_done = v.done; mem_data_in = v.data;
        decode_ready = v.rdy; redirect = v.redir; redirect_pc = v.rpc; halt = v.halt;
        #1;
        chk(v.name, "mem_rd", 16'(mem_rd), 16'(v.e_rd));
        if (v.e_rd) chk(v.name, "mem_addr", mem_addr, v.e_addr);
        if (v.ck) begin
            chk(v.name, "instr_valid", 16'(instr_valid), 16'(v.e_valid));
            chk(v.name, "err", 16'(err), 16'(v.e_err));
            if (v.e_valid) begin
                chk(v.name, "instr", instr, v.e_instr);
                chk(v.name, "pc_plus", pc_plus, v.e_pcp);
            end
        end
    endtask

    task automatic run_queue();
        foreach (vq[i]) apply(vq[i]);
        vq.delete();
    endtask

    initial begin
        rst = 1'b1; mem_stall = 1'b0; mem_done = 1'b0; mem_data_in = 16'h0;
        decode_ready = 1'b1; redirect = 1'b0; redirect_pc = 16'h0; halt = 1'b0;
        repeat (2) @(posedge clk);

        // Basic in-order flow, memory answers one cycle after accept
        add_rst("b0");
        add("b1", 0,0,0,16'h0000,1,0,16'h0,0, 1,16'h0000, 0,16'h0,16'h0, 0);
        add("b2", 0,0,1,16'hA000,1,0,16'h0,0, 0,16'h0000, 0,16'h0,16'h0, 0);
        add("b3", 0,0,0,16'h0000,1,0,16'h0,0, 1,16'h0002, 1,16'hA000,16'h0002, 0);
        add("b4", 0,0,1,16'hA002,1,0,16'h0,0, 0,16'h0000, 0,16'h0,16'h0, 0);
        add("b5", 0,0,0,16'h0000,1,0,16'h0,0, 1,16'h0004, 1,16'hA002,16'h0004, 0);
        add("b6", 0,0,1,16'hA004,1,0,16'h0,0, 0,16'h0000, 0,16'h0,16'h0, 0);
        add("b7", 0,0,0,16'h0000,1,0,16'h0,0, 1,16'h0006, 1,16'hA004,16'h0006, 0);

        // Decode back-pressure: two reads fill the buffer, then fetch stalls
        add_rst("d0");
        add("d1", 0,0,0,16'h0000,0,0,16'h0,0, 1,16'h0000, 0,16'h0,16'h0, 0);
        add("d2", 0,0,1,16'hB000,0,0,16'h0,0, 0,16'h0000, 0,16'h0,16'h0, 0);
        add("d3", 0,0,0,16'h0000,0,0,16'h0,0, 1,16'h0002, 1,16'hB000,16'h0002, 0);
        add("d4", 0,0,1,16'hB002,0,0,16'h0,0, 0,16'h0000, 1,16'hB000,16'h0002, 0);
        add("d5", 0,0,0,16'h0000,0,0,16'h0,0, 0,16'h0000, 1,16'hB000,16'h0002, 0);
        add("d6", 0,0,0,16'h0000,0,0,16'h0,0, 0,16'h0000, 1,16'hB000,16'h0002, 0);
        add("d7", 0,0,0,16'h0000,1,0,16'h0,0, 0,16'h0000, 1,16'hB000,16'h0002, 0);
        add("d8", 0,0,0,16'h0000,1,0,16'h0,0, 1,16'h0004, 1,16'hB002,16'h0004, 0);
        add("d9", 0,0,1,16'hB004,1,0,16'h0,0, 0,16'h0000, 0,16'h0,16'h0, 0);
        add("d10",0,0,0,16'h0000,1,0,16'h0,0, 1,16'h0006, 1,16'hB004,16'h0006, 0);

        // Memory stall holds the request; then the FFFE -> 0000 wrap
        add_rst("s0");
        add("s1", 0,1,0,16'h0000,1,0,16'h0,0, 1,16'h0000, 0,16'h0,16'h0, 0);
        add("s2", 0,1,0,16'h0000,1,0,16'h0,0, 1,16'h0000, 0,16'h0,16'h0, 0);
        add("s3", 0,1,0,16'h0000,1,0,16'h0,0, 1,16'h0000, 0,16'h0,16'h0, 0);
        add("s4", 0,0,0,16'h0000,1,0,16'h0,0, 1,16'h0000, 0,16'h0,16'h0, 0);
        add("s5", 0,0,1,16'hC000,1,0,16'h0,0, 0,16'h0000, 0,16'h0,16'h0, 0);
        add("s6", 0,0,0,16'h0000,1,1,16'hFFFE,0, 0,16'h0000, 1,16'hC000,16'h0002, 0);
        add("s7", 0,0,0,16'h0000,1,0,16'h0,0, 1,16'hFFFE, 0,16'h0,16'h0, 0);
        add("s8", 0,0,1,16'hC0FE,1,0,16'h0,0, 0,16'h0000, 0,16'h0,16'h0, 0);
        add("s9", 0,0,0,16'h0000,1,0,16'h0,0, 1,16'h0000, 1,16'hC0FE,16'h0000, 0);

        // Redirect while a read is pending: returned word must be dropped
        add_rst("w0");
        add("w1", 0,0,0,16'h0000,1,0,16'h0,0, 1,16'h0000, 0,16'h0,16'h0, 0);
        add("w2", 0,0,0,16'h0000,1,1,16'h0040,0, 0,16'h0000, 0,16'h0,16'h0, 0);
        add("w3", 0,0,1,16'h1234,1,0,16'h0,0, 0,16'h0000, 0,16'h0,16'h0, 0);
        add("w4", 0,0,0,16'h0000,1,0,16'h0,0, 1,16'h0040, 0,16'h0,16'h0, 0);
        add("w5", 0,0,1,16'hD040,1,0,16'h0,0, 0,16'h0000, 0,16'h0,16'h0, 0);
        add("w6", 0,0,0,16'h0000,1,0,16'h0,0, 1,16'h0042, 1,16'hD040,16'h0042, 0);

        // Redirect coinciding with mem_done
        add_rst("x0");
        add("x1", 0,0,0,16'h0000,1,0,16'h0,0, 1,16'h0000, 0,16'h0,16'h0, 0);
        add("x2", 0,0,1,16'h5555,1,1,16'h0080,0, 0,16'h0000, 0,16'h0,16'h0, 0);
        add("x3", 0,0,0,16'h0000,1,0,16'h0,0, 1,16'h0080, 0,16'h0,16'h0, 0);
        add("x4", 0,0,1,16'hE080,1,0,16'h0,0, 0,16'h0000, 0,16'h0,16'h0, 0);
        add("x5", 0,0,0,16'h0000,1,0,16'h0,0, 1,16'h0082, 1,16'hE080,16'h0082, 0);

        // Reset during WAIT; the late mem_done is a stray
        add_rst("a0");
        add("a1", 0,0,0,16'h0000,1,0,16'h0,0, 1,16'h0000, 0,16'h0,16'h0, 0);
        add_rst("a2");
        add("a3", 0,0,1,16'h7777,1,0,16'h0,0, 1,16'h0000, 0,16'h0,16'h0, 0);
        add("a4", 0,0,0,16'h0000,1,0,16'h0,0, 0,16'h0000, 0,16'h0,16'h0, 1);

        // Misaligned redirect target flags err
        add_rst("m0");
        add("m1", 0,0,0,16'h0000,1,0,16'h0,0, 1,16'h0000, 0,16'h0,16'h0, 0);
        add_rst("m2");
        add("m3", 0,0,0,16'h0000,1,1,16'h0041,0, 0,16'h0000, 0,16'h0,16'h0, 0);
        add("m4", 0,0,0,16'h0000,1,0,16'h0,0, 1,16'h0041, 0,16'h0,16'h0, 1);
        run_queue();

        // Halt with one read outstanding, then sticky HALTED and sticky err
        add_rst("h0");
        add("h1", 0,0,0,16'h0000,1,0,16'h0,0, 1,16'h0000, 0,16'h0,16'h0, 0);
        add("h2", 0,0,0,16'h0000,1,0,16'h0,1, 0,16'h0000, 0,16'h0,16'h0, 0);
        add("h3", 0,0,1,16'hF000,1,0,16'h0,0, 0,16'h0000, 0,16'h0,16'h0, 0);
        add("h4", 0,0,0,16'h0000,1,0,16'h0,0, 0,16'h0000, 1,16'hF000,16'h0002, 0);
        for (int i = 0; i < 20; i++)
            add($sformatf("hr%0d", i), 0,0,0,16'h0000,1,1,16'h0100,0,
                0,16'h0000, 0,16'h0,16'h0, 0);
        add("h5", 0,0,1,16'h9999,1,0,16'h0,0, 0,16'h0000, 0,16'h0,16'h0, 0);
        for (int i = 0; i < 4; i++)
            add($sformatf("he%0d", i), 0,0,0,16'h0000,1,0,16'h0,0,
                0,16'h0000, 0,16'h0,16'h0, 1);
        add_rst("h6");
        add("h7", 0,0,0,16'h0000,1,0,16'h0,0, 1,16'h0000, 0,16'h0,16'h0, 0);
        run_queue();

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction fetch stage that sits directly upstream of the processor's decode/execute datapath and replaces its direct instruction-memory read with a stalling memory interface. It owns the fetch PC and issues one instruction read at a time to a multi-cycle memory. Returned words go into a 2-entry buffer, which presents each instruction together with its PC+2 value to decode through a valid/ready handshake. Branch, jump and JR redirects from execute flush the buffer and discard any in-flight read; HALT stops fetching permanently until reset.

## Interface
- RESET_PC, 16'h0000, fetch address after reset.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_rd  out  1  read request to instruction memory.
- mem_addr  out  16  read address; equals fetch_pc whenever mem_rd=1.
- mem_stall  in  1  memory busy; request not accepted this cycle.
- mem_done  in  1  one-cycle pulse; mem_data_in valid.
- mem_data_in  in  16  returned instruction word.
- instr  out  16  head-of-buffer instruction.
- pc_plus  out  16  address of instr + 2.
- instr_valid  out  1  buffer non-empty.
- decode_ready  in  1  decode consumes head when instr_valid & decode_ready.
- redirect  in  1  taken branch/jump/JR this cycle.
- redirect_pc  in  16  new fetch target.
- halt  in  1  HALT decoded; sticky stop.
- err  out  1  sticky protocol/alignment error.

## Operation
- States: IDLE (no read outstanding), WAIT (read accepted, data pending), DROP (flushed read pending, data to be discarded), HALTED.
- Credit rule: issue only if occupancy + outstanding < 2, so a push never overflows the buffer.
- mem_rd = (state==IDLE) & credit & ~redirect & ~halt & ~halt_seen & ~rst; combinational.
- Accept = mem_rd & ~mem_stall: fetch_pc <= fetch_pc + 2 (mod 2^16, wraps FFFE→0000); tag_pc <= fetch_pc + 2; IDLE→WAIT.
- WAIT & mem_done: push {mem_data_in, tag_pc}; →IDLE.
- Pop on instr_valid & decode_ready; push and pop in the same cycle are both allowed, and occupancy is unchanged.
- Redirect (priority over everything except rst): buffer emptied; fetch_pc <= redirect_pc. WAIT without mem_done that cycle→DROP. WAIT with mem_done that cycle: data discarded, →IDLE. Otherwise →IDLE. A pop in the same cycle is ignored.
- DROP & mem_done: data discarded; →IDLE. A further redirect in DROP only updates fetch_pc.
- halt=1: halt_seen set. No new issue. An outstanding read completes and is pushed normally. When state reaches IDLE with halt_seen set →HALTED. Buffered words remain available to decode.
- HALTED: redirect and halt ignored; mem_rd=0; exit only via rst.
- err set by: mem_done in IDLE or HALTED; redirect_pc[0]=1 on redirect; mem_stall changing while mem_rd=1 and redirect=0 is not an error. err holds until rst.

## Timing
- Reset (rst high at an edge): fetch_pc=RESET_PC, state IDLE, buffer empty, instr_valid=0, err=0, halt_seen=0. mem_rd=0 while rst=1.
- rst in any state, including WAIT or DROP, aborts everything. A mem_done arriving after reset is treated as a stray and sets err; the memory must also be reset.
- Earliest path: accept at cycle N, mem_done at N+1, instr_valid=1 at N+2. The next request can be issued in cycle N+2, because mem_done frees IDLE at the N+1 edge.
- instr and pc_plus are registered buffer outputs, stable while instr_valid & ~decode_ready.
- Redirect at cycle N: instr_valid=0 at N+1; the first read of redirect_pc can issue at N+1 if no read is pending.
- Throughput with zero-latency memory: one instruction per 2 cycles.

## Test plan
- Reset with RESET_PC=0, mem_done one cycle after each accept, decode_ready=1 -> mem_addr sequence 0000,0002,0004; instrs delivered in order with pc_plus 0002,0004,0006.
- decode_ready=0 held -> exactly 2 reads issued, then mem_rd stays 0. After decode_ready=1, the buffered words drain in order and fetching resumes at 0004.
- mem_stall=1 for 3 cycles with mem_rd=1 -> mem_addr holds 0000 and is accepted on cycle 4. Later, fetch_pc=FFFE -> next mem_addr=0000.
- Redirect to 0040 while in WAIT, then mem_done with 1234 -> 1234 never presented, the next accepted mem_addr is 0040, err=0.
- Redirect in the same cycle as mem_done -> data discarded, state IDLE, next mem_addr = redirect_pc.
- halt with one read outstanding -> that word is delivered, then HALTED and mem_rd stays 0 for 20 cycles despite redirect. Stray mem_done -> err=1 until rst. Redirect_pc=0041 after reset -> err=1.
